// File: rtl/imm_narrow.sv
// imm_narrow: streaming signed IN_W -> OUT_W immediate encoder with overflow flag,
// saturating overflow counter and a 2-entry skid buffer.
// Optional build macro IMM_NARROW_SATURATE_EN: clamp overflowing words instead of wrapping.
// Ports: clk; rst (async, active-high);
//        in_valid/in_ready/in_data   : input word stream (in_ready registered);
//        out_valid/out_ready/out_imm/out_ovf : narrowed immediate stream;
//        ovf_cnt : number of accepted words that overflowed (saturating).
module imm_narrow #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 12,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t           r_state;
    logic             r_in_ready, r_out_valid, r_h_ovf, r_s_ovf;
    logic [OUT_W-1:0] r_h_imm, r_s_imm;
    logic [CNT_W-1:0] r_cnt;
    logic [IN_W-OUT_W:0] w_top;
    logic             w_ovf, w_in_x, w_out_x;
    logic [OUT_W-1:0] w_imm;
    // Word fits iff the bits from the result's sign bit upward are all equal.
    assign w_top = in_data[IN_W-1:OUT_W-1];
    assign w_ovf = |w_top & ~&w_top;
`ifdef IMM_NARROW_SATURATE_EN
    // Clamp toward the input's sign: 0111..1 for positive, 1000..0 for negative.
    assign w_imm = w_ovf ? {in_data[IN_W-1], {(OUT_W-1){~in_data[IN_W-1]}}} : in_data[OUT_W-1:0];
`else
    assign w_imm = in_data[OUT_W-1:0];
`endif
    assign w_in_x    = in_valid & r_in_ready;
    assign w_out_x   = r_out_valid & out_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_imm   = r_h_imm;
    assign out_ovf   = r_h_ovf;
    assign ovf_cnt   = r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_h_imm     <= '0;
            r_h_ovf     <= 1'b0;
            r_s_imm     <= '0;
            r_s_ovf     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_in_x && w_ovf && !(&r_cnt))
                r_cnt <= r_cnt + CNT_W'(1);
            case (r_state)
                EMPTY: if (w_in_x) begin
                    r_h_imm     <= w_imm;
                    r_h_ovf     <= w_ovf;
                    r_out_valid <= 1'b1;
                    r_state     <= ONE;
                end
                ONE: if (w_in_x && w_out_x) begin
                    r_h_imm <= w_imm;
                    r_h_ovf <= w_ovf;
                end else if (w_in_x) begin
                    r_s_imm    <= w_imm;
                    r_s_ovf    <= w_ovf;
                    r_in_ready <= 1'b0;
                    r_state    <= TWO;
                end else if (w_out_x) begin
                    r_out_valid <= 1'b0;
                    r_state     <= EMPTY;
                end
                TWO: if (w_out_x) begin
                    r_h_imm    <= r_s_imm;
                    r_h_ovf    <= r_s_ovf;
                    r_in_ready <= 1'b1;
                    r_state    <= ONE;
                end
                default: r_state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_imm_narrow.sv
// tb_imm_narrow: self-checking bench for imm_narrow (queue reference model + vector table).
module tb_imm_narrow;
    localparam int IN_W = 32, OUT_W = 12, CNT_W = 4;
    logic clk = 0, rst = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, out_ovf;
    logic [IN_W-1:0]  in_data = '0;
    logic [OUT_W-1:0] out_imm;
    logic [CNT_W-1:0] ovf_cnt;

    imm_narrow #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_ovf(out_ovf),
        .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IN_W-1:0]  d;
        logic [OUT_W-1:0] imm;
        logic             ovf;
    } exp_t;

    exp_t q[$];
    int n_vec = 0, n_err = 0, cnt_m = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [IN_W-1:0] d);
        exp_t e;
        longint v  = longint'($signed(d));
        longint hi = (longint'(1) << (OUT_W - 1)) - 1;
        longint lo = -(longint'(1) << (OUT_W - 1));
        e.d   = d;
        e.ovf = (v > hi) || (v < lo);
`ifdef IMM_NARROW_SATURATE_EN
        if (v > hi) v = hi;
        else if (v < lo) v = lo;
`endif
        e.imm = OUT_W'(v);
        return e;
    endfunction

    task automatic cycle(input logic iv, input logic [IN_W-1:0] d, input logic ordy,
                         input exp_t e, output logic acc);
        in_valid = iv; in_data = d; out_ready = ordy;
        @(negedge clk);
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("ovf_cnt", ovf_cnt, cnt_m);
        if (q.size() != 0) begin
            chk("out_imm", out_imm, q[0].imm);
            chk("out_ovf", out_ovf, q[0].ovf);
            if (!q[0].ovf)
                chk("roundtrip", {{(IN_W-OUT_W){out_imm[OUT_W-1]}}, out_imm}, q[0].d);
        end
        acc = iv && q.size() < 2;
        @(posedge clk);
        if (q.size() != 0 && ordy) void'(q.pop_front());
        if (acc) begin
            q.push_back(e);
            if (e.ovf && cnt_m < (1 << CNT_W) - 1) cnt_m++;
        end
        #1;
    endtask

    task automatic send(input exp_t e, input logic ordy);
        logic acc;
        int n = 0;
        do begin
            cycle(1'b1, e.d, ordy, e, acc);
            n++;
        end while (!acc && n < 20);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        exp_t e0;
        e0 = model('0);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, ordy, e0, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);
        q.delete();
        cnt_m = 0;
        in_valid = 0;
        @(negedge clk) rst = 0;
        @(posedge clk) #1;
    endtask

    exp_t tbl[11];
    logic [OUT_W-1:0] p_ovf, n_ovf, l_ovf;

    initial begin
        logic acc, have;
        logic [IN_W-1:0] pd;
`ifdef IMM_NARROW_SATURATE_EN
        p_ovf = 12'h7FF; n_ovf = 12'h800; l_ovf = 12'h7FF;
`else
        p_ovf = 12'h800; n_ovf = 12'h7FF; l_ovf = 12'h005;
`endif
        tbl[0]  = '{d: 32'd5,         imm: 12'h005, ovf: 1'b0};
        tbl[1]  = '{d: 32'd12,        imm: 12'h00C, ovf: 1'b0};
        tbl[2]  = '{d: 32'hFFFFFFFB,  imm: 12'hFFB, ovf: 1'b0};
        tbl[3]  = '{d: 32'hFFFFFFF4,  imm: 12'hFF4, ovf: 1'b0};
        tbl[4]  = '{d: 32'd1337,      imm: 12'h539, ovf: 1'b0};
        tbl[5]  = '{d: 32'hFFFFF81D,  imm: 12'h81D, ovf: 1'b0};
        tbl[6]  = '{d: 32'd2047,      imm: 12'h7FF, ovf: 1'b0};
        tbl[7]  = '{d: 32'hFFFFF800,  imm: 12'h800, ovf: 1'b0};
        tbl[8]  = '{d: 32'd2048,      imm: p_ovf,   ovf: 1'b1};
        tbl[9]  = '{d: 32'hFFFFF7FF,  imm: n_ovf,   ovf: 1'b1};
        tbl[10] = '{d: 32'h00001005,  imm: l_ovf,   ovf: 1'b1};

        do_reset();

        for (int i = 0; i < 11; i++) send(tbl[i], 1'b1);
        idle(3, 1'b1);
        chk("ovf_cnt_table", ovf_cnt, 3);

        send(model(32'd100), 1'b0);
        send(model(32'hFFFFFF9C), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'd7, 1'b0, model(32'd7), acc);
        send(model(32'd7), 1'b1);
        idle(3, 1'b1);

        have = 0;
        pd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!have) begin
                pd = ($urandom_range(0, 2) == 0) ? IN_W'($urandom)
                                                 : IN_W'(int'($urandom_range(0, 8191)) - 4096);
                have = 1;
            end
            cycle($urandom_range(0, 3) != 0, pd, $urandom_range(0, 3) != 0, model(pd), acc);
            if (acc) have = 0;
        end
        idle(3, 1'b1);

        do_reset();
        for (int i = 0; i < 20; i++) send(model(32'h80000000 + IN_W'(i)), 1'b1);
        idle(2, 1'b1);
        chk("ovf_cnt_sat", ovf_cnt, 15);

        send(model(32'd300), 1'b0);
        send(model(32'h00002000), 1'b0);
        do_reset();
        send(model(32'd5), 1'b1);
        idle(2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
